mux4_rr_arbiter: RTL and testbench

- Four-requester round-robin arbiter that owns the select lines of the 4-way 1-bit mux.
- Grants the shared mux path to one requester at a time and holds the grant while that requester keeps `req` high.
- Drives `select` and a one-hot `grant`, and routes `data_in` through an internal `mux4` instance to `out`.
- Sits between requesting units and any downstream single-bit consumer.

---
 rtl/mux4_arb_pkg.sv | 31 +++
 rtl/mux4.sv | 25 ++
 rtl/mux4_rr_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/mux4_arb_pkg.sv
// rtl/mux4_arb_pkg.sv - shared types and round-robin pick helper for mux4_rr_arbiter
//
// Purpose: FSM state enum, request vector type, requester count and the
// rotating first-set-bit search used by the arbiter.
// Ports: none (package).
package mux4_arb_pkg;

  localparam int NREQ_C = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  typedef logic [3:0] req_vec_t;

  // Returns {found, idx}: the first set bit of req scanning ptr, ptr+1, ...
  // modulo 4. Walking the offsets from the far end lets the nearest hit
  // overwrite any farther one.
  function automatic logic [2:0] rr_pick(input req_vec_t req, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

endpackage

// File: rtl/mux4.sv
// rtl/mux4.sv - 4-way 1-bit multiplexer datapath
//
// Purpose: routes one of four data bits to the output.
// Ports:
//   d   - four candidate data bits
//   sel - index of the bit to route
//   y   - d[sel]
module mux4 (
  input  logic [3:0] d,
  input  logic [1:0] sel,
  output logic       y
);

  always_comb begin
    y = 1'b0;
    case (sel)
      2'd0: y = d[0];
      2'd1: y = d[1];
      2'd2: y = d[2];
      2'd3: y = d[3];
      default: y = 1'b0;
    endcase
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - four-requester round-robin arbiter driving a mux4 select
//
// Purpose: grants the shared 1-bit mux path to one requester at a time,
// holding the grant while that requester keeps req high, and routes the
// owner's data bit to out.
// Optional feature macro: MUX4_ARB_TIMEOUT_EN (bounds a grant to HOLD_MAX
// cycles when another requester is waiting).
// Ports:
//   clk     - clock, all state changes on the rising edge
//   rst     - synchronous active-high reset
//   req     - per-requester request, bit i is requester i
//   data_in - per-requester data bit
//   grant   - registered one-hot grant, zero when idle
//   select  - registered mux select, index of the owner
//   busy    - registered, high while a grant is active
//   out     - data_in[select] while busy, else 0
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] data_in,
  output logic [3:0] grant,
  output logic [1:0] select,
  output logic       busy,
  output logic       out
);

  generate
    if (NREQ != NREQ_C) begin : g_nreq_chk
      $error("mux4_rr_arbiter: NREQ must be 4 to match the mux width");
    end
    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_chk
      $error("mux4_rr_arbiter: HOLD_MAX must be in 1..255");
    end
  endgenerate

  arb_state_t state_q, state_d;
  req_vec_t   grant_q, grant_d;
  logic [1:0] select_q, select_d;
  logic       busy_q, busy_d;
  logic [1:0] ptr_q, ptr_d;

  logic [2:0] pick;
  logic       new_grant;
  req_vec_t   others;

  // Requests from everyone except the current owner.
  assign others = req & ~grant_q;

`ifdef MUX4_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
  logic [7:0] hold_q, hold_d;
  logic       preempt;

  assign preempt = (hold_q >= HOLD_LAST) && (others != '0);
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    select_d  = select_q;
    busy_d    = busy_q;
    ptr_d     = ptr_q;
    pick      = 3'b000;
    new_grant = 1'b0;

    case (state_q)
      IDLE: begin
        pick      = rr_pick(req, ptr_q);
        new_grant = pick[2];
      end
      GRANT: begin
        if (!req[select_q]) begin
          // Owner left: hand over in the same edge, scanning past the owner.
          pick = rr_pick(req, select_q + 2'd1);
          if (pick[2]) begin
            new_grant = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
          end
        end
`ifdef MUX4_ARB_TIMEOUT_EN
        else if (preempt) begin
          pick      = rr_pick(others, select_q + 2'd1);
          new_grant = 1'b1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase

    if (new_grant) begin
      state_d  = GRANT;
      grant_d  = req_vec_t'(4'b0001 << pick[1:0]);
      select_d = pick[1:0];
      busy_d   = 1'b1;
      ptr_d    = pick[1:0] + 2'd1;
    end
  end

`ifdef MUX4_ARB_TIMEOUT_EN
  // Counts cycles of the current grant; parks at HOLD_LAST when nobody
  // else is waiting so the owner keeps the path.
  always_comb begin
    hold_d = hold_q;
    if (new_grant) begin
      hold_d = '0;
    end else if (state_q == GRANT && hold_q < HOLD_LAST) begin
      hold_d = hold_q + 8'd1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      select_q <= 2'd0;
      busy_q   <= 1'b0;
      ptr_q    <= 2'd0;
`ifdef MUX4_ARB_TIMEOUT_EN
      hold_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      select_q <= select_d;
      busy_q   <= busy_d;
      ptr_q    <= ptr_d;
`ifdef MUX4_ARB_TIMEOUT_EN
      hold_q   <= hold_d;
`endif
    end
  end

  logic mux_y;

  mux4 u_mux4 (
    .d   (data_in),
    .sel (select_q),
    .y   (mux_y)
  );

  assign grant  = grant_q;
  assign select = select_q;
  assign busy   = busy_q;
  assign out    = busy_q & mux_y;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb/tb_mux4_rr_arbiter.sv - directed self-checking bench for mux4_rr_arbiter
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] data_in;
  logic [3:0] grant;
  logic [1:0] select;
  logic       busy;
  logic       out;

  int checks   = 0;
  int failures = 0;

  mux4_rr_arbiter #(.NREQ(4), .HOLD_MAX(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .data_in (data_in),
    .grant   (grant),
    .select  (select),
    .busy    (busy),
    .out     (out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [3:0] g, input logic [1:0] s,
                            input logic b, input logic o);
    check({tag, ".grant"},  32'(grant),  32'(g));
    check({tag, ".select"}, 32'(select), 32'(s));
    check({tag, ".busy"},   32'(busy),   32'(b));
    check({tag, ".out"},    32'(out),    32'(o));
  endtask

  logic [3:0] rr_drop [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [3:0] rr_exp  [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [1:0] rr_sel  [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
`ifdef MUX4_ARB_TIMEOUT_EN
  logic [3:0] to_exp [8] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010,
                             4'b0010, 4'b0001, 4'b0001, 4'b0001};
`else
  logic [3:0] to_exp [8] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001,
                             4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif

  initial begin
    rst     = 1'b1;
    req     = 4'b1111;
    data_in = 4'b1111;

    // Reset held two cycles with all requests up.
    tick();
    check_outs("rst1", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    check_outs("rst2", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    check_outs("rel", 4'b0001, 2'd0, 1'b1, 1'b1);

    // Go idle; ptr is now 1.
    req = 4'b0000;
    tick();
    check_outs("idle0", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Single requester 2 for five cycles.
    req     = 4'b0100;
    data_in = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_outs($sformatf("single%0d", i), 4'b0100, 2'd2, 1'b1, 1'b1);
    end
    req = 4'b0000;
    tick();
    check_outs("single_drop", 4'b0000, 2'd2, 1'b0, 1'b0);

    // Round robin with all requesting, starting from a fresh pointer.
    rst = 1'b1;
    req = 4'b1111;
    tick();
    rst = 1'b0;
    tick();
    check("rr0.grant", 32'(grant), 32'(4'b0001));
    tick();
    check("rr0.hold", 32'(grant), 32'(4'b0001));
    for (int k = 0; k < 4; k++) begin
      req = rr_drop[k];
      tick();
      check($sformatf("rr%0d.grant", k + 1), 32'(grant), 32'(rr_exp[k]));
      check($sformatf("rr%0d.select", k + 1), 32'(select), 32'(rr_sel[k]));
      check($sformatf("rr%0d.busy", k + 1), 32'(busy), 32'(1'b1));
      req = 4'b1111;
      tick();
      check($sformatf("rr%0d.hold", k + 1), 32'(grant), 32'(rr_exp[k]));
    end

    // Pointer wrap: grant 3, release, then requesters 0 and 3.
    req = 4'b1000;
    tick();
    check("wrap.g3", 32'(grant), 32'(4'b1000));
    req = 4'b0000;
    tick();
    check("wrap.idle", 32'(busy), 32'(1'b0));
    req = 4'b1001;
    tick();
    check("wrap.g0", 32'(grant), 32'(4'b0001));

    // out follows data_in of the owner combinationally.
    data_in = 4'b1110;
    #1;
    check("data.lo", 32'(out), 32'(1'b0));
    data_in = 4'b0001;
    #1;
    check("data.hi", 32'(out), 32'(1'b1));

    // Reset in the middle of a grant to requester 1.
    req = 4'b0010;
    tick();
    check("mid.g1", 32'(grant), 32'(4'b0010));
    rst = 1'b1;
    tick();
    check_outs("mid.rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    req = 4'b0011;
    tick();
    check_outs("mid.after", 4'b0001, 2'd0, 1'b1, 1'b1);

    // Two requesters held: timeout alternates owners, otherwise owner keeps it.
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("hold%0d", i), 32'(grant), 32'(to_exp[i]));
    end
    req = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("solo%0d", i), 32'(grant), 32'(4'b0001));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
